commit_trace_fifo: RTL and testbench
====================================

Name: commit_trace_fifo

Overview:
Buffers the retired-instruction stream leaving the mp4 MEM/WB commit point. Each committed instruction becomes a trace record carrying a monotonically increasing order number. Records drain through a valid/ready port to the shadow-memory checker, trace dumper or perf logger. The block also detects the self-loop halt condition and accounts for overflow drops so the checker can flag gaps.

Parameters:
DEPTH, 16, number of trace records stored; power of two, at least 2.
ORDER_W, 64, width of the commit order counter.

Ports:
clk  input  1  clock
rst  input  1  asynchronous, active-low reset
commit_valid  input  1  an instruction commits this cycle
commit_pc_rdata  input  32  PC of the committing instruction
commit_pc_wdata  input  32  next PC after the instruction
commit_inst  input  32  instruction word
commit_rd_addr  input  5  destination register
commit_rd_wdata  input  32  destination write data
commit_load_regfile  input  1  instruction writes the regfile
commit_trap  input  1  illegal or trapped instruction
flush  input  1  synchronous clear of the buffer and status
out_valid  output  1  head record is valid
out_ready  input  1  consumer accepts the head record
out_order  output  ORDER_W  order number of the head record
out_pc  output  32  head pc_rdata
out_next_pc  output  32  head pc_wdata
out_inst  output  32  head instruction word
out_rd_addr  output  5  head rd
out_rd_wdata  output  32  head rd data, masked
out_trap  output  1  head trap flag
count  output  $clog2(DEPTH)+1  occupancy
overflow  output  1  sticky; at least one record dropped
drop_count  output  32  number of dropped records, saturating
halted  output  1  sticky halt detected

Behaviour:
- Reset (rst low, asynchronous): all outputs are 0, pointers are 0, order counter is 0.
- The FIFO is first-word-fall-through with circular read/write pointers. Pointers wrap at DEPTH.
- Push request: push = commit_valid && !halted && !flush.
- Pop: pop = out_valid && out_ready. The head advances on the clock edge.
- Latency: a record pushed into an empty FIFO sets out_valid the next cycle. There is no same-cycle bypass.
- Order counter:
  - Increments on every push request, accepted or dropped, so drops appear as order gaps.
  - Each record captures the pre-increment value.
  - The counter wraps modulo 2^ORDER_W.
- Full without a simultaneous pop: the record is dropped.
  - overflow is set to 1.
  - drop_count increments, saturating at 0xFFFFFFFF.
  - count stays at DEPTH.
- Full with a simultaneous pop: the push is accepted and count is unchanged.
- Empty: out_valid is 0. out_ready is ignored and nothing underflows.
- Data masking: out_rd_wdata is stored as 0 when commit_rd_addr==0 or commit_load_regfile==0. out_rd_addr is stored unmasked.
- Halt detection: triggered by push && commit_pc_wdata==commit_pc_rdata && commit_pc_rdata!=0.
  - The halting record itself is enqueued, or dropped if the FIFO is full.
  - halted goes to 1 on the following edge.
  - Later commits are ignored. They do not count as drops and do not advance the order counter.
  - Draining continues normally while halted.
- Trap records are stored with out_trap=1. A trap does not set halted.
- flush (synchronous, highest priority):
  - Empties the FIFO.
  - Clears count, overflow, drop_count and halted.
  - Does not reset the order counter.
  - A commit arriving in the same cycle is discarded and not counted.
  - A pop in the same cycle has no further effect.
- State is the FIFO plus the halt flag with two states: RUN→HALTED on a halt condition; HALTED→RUN only on flush or reset.
- Reset mid-operation: all state is lost immediately and outputs return to their reset values asynchronously.
- Output record fields are driven from the storage entry at the read pointer. They are don't-care while out_valid=0, but the bench may check that they are 0 after reset.

Test Plan:
1. Directed drain: three commits with PC 0x60000000/04/08 and out_ready=1. out_valid rises one cycle after the first commit. Records appear in order with out_order 0, 1, 2. count returns to 0.
2. Overflow: hold out_ready=0 and issue 18 commits.
   - Expect count=16, overflow=1, drop_count=2.
   - Drain shows orders 0..15.
   - The next accepted commit carries order 18.
3. Full plus simultaneous push/pop at count=16: count stays 16. drop_count is unchanged. The tail record is the new commit.
4. Halt: commit with pc_rdata=pc_wdata=0x600000A0.
   - The record is enqueued and halted=1 the next cycle.
   - Five further commits are ignored: count, drop_count and order are all unchanged.
   - A self-loop at PC 0 does not halt.
   - flush clears halted.
5. Masking: rd_addr=0, rd_wdata=0xDEADBEEF, load_regfile=1 gives out_rd_wdata=0. rd_addr=5 with load_regfile=0 also gives 0.
6. Reset mid-operation: with count=7 and overflow=1, pulse rst low for one cycle mid-cycle. All outputs read 0 immediately. The next commit gets order 0.

Source files
------------

// File: rtl/commit_trace_fifo.sv
// commit_trace_fifo: FWFT buffer of retired-instruction trace records with order numbering, overflow accounting and self-loop halt detection
module commit_trace_fifo #(
    parameter int DEPTH   = 16,
    parameter int ORDER_W = 64
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       commit_valid,
    input  logic [31:0]                commit_pc_rdata,
    input  logic [31:0]                commit_pc_wdata,
    input  logic [31:0]                commit_inst,
    input  logic [4:0]                 commit_rd_addr,
    input  logic [31:0]                commit_rd_wdata,
    input  logic                       commit_load_regfile,
    input  logic                       commit_trap,
    input  logic                       flush,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [ORDER_W-1:0]         out_order,
    output logic [31:0]                out_pc,
    output logic [31:0]                out_next_pc,
    output logic [31:0]                out_inst,
    output logic [4:0]                 out_rd_addr,
    output logic [31:0]                out_rd_wdata,
    output logic                       out_trap,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic [31:0]                drop_count,
    output logic                       halted
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic {RUN, HALTED} state_t;

    state_t state, state_next;
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [ORDER_W-1:0] order;
    logic [ORDER_W-1:0] mem_order [DEPTH];
    logic [31:0] mem_pc [DEPTH];
    logic [31:0] mem_next_pc [DEPTH];
    logic [31:0] mem_inst [DEPTH];
    logic [4:0] mem_rd_addr [DEPTH];
    logic [31:0] mem_rd_wdata [DEPTH];
    logic mem_trap [DEPTH];
    logic push, pop, full, accept, drop, halt_hit;
    logic [31:0] masked_wdata;

    assign push         = commit_valid && !halted && !flush;
    assign full         = count == CW'(DEPTH);
    assign out_valid    = count != '0;
    assign pop          = out_valid && out_ready;
    assign accept       = push && (!full || pop);
    assign drop         = push && full && !pop;
    assign halt_hit     = push && commit_pc_wdata == commit_pc_rdata && commit_pc_rdata != '0;
    assign masked_wdata = (commit_rd_addr != '0 && commit_load_regfile) ? commit_rd_wdata : '0;

    assign out_order    = mem_order[rd_ptr];
    assign out_pc       = mem_pc[rd_ptr];
    assign out_next_pc  = mem_next_pc[rd_ptr];
    assign out_inst     = mem_inst[rd_ptr];
    assign out_rd_addr  = mem_rd_addr[rd_ptr];
    assign out_rd_wdata = mem_rd_wdata[rd_ptr];
    assign out_trap     = mem_trap[rd_ptr];

    // halt state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= RUN;
        else      state <= state_next;
    end

    // halt is sticky until flush
    always_comb begin
        state_next = flush ? RUN : (state == RUN && halt_hit) ? HALTED : state;
    end

    // halt flag decode
    always_comb begin
        halted = state == HALTED;
    end

    // storage, pointers, occupancy, order numbering and drop accounting
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            order      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_order[i]    <= '0;
                mem_pc[i]       <= '0;
                mem_next_pc[i]  <= '0;
                mem_inst[i]     <= '0;
                mem_rd_addr[i]  <= '0;
                mem_rd_wdata[i] <= '0;
                mem_trap[i]     <= 1'b0;
            end
        end else if (flush) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
        end else begin
            if (push) order <= order + 1'b1;
            if (accept) begin
                mem_order[wr_ptr]    <= order;
                mem_pc[wr_ptr]       <= commit_pc_rdata;
                mem_next_pc[wr_ptr]  <= commit_pc_wdata;
                mem_inst[wr_ptr]     <= commit_inst;
                mem_rd_addr[wr_ptr]  <= commit_rd_addr;
                mem_rd_wdata[wr_ptr] <= masked_wdata;
                mem_trap[wr_ptr]     <= commit_trap;
                wr_ptr               <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            if (accept && !pop) count <= count + 1'b1;
            else if (pop && !accept) count <= count - 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + 1'b1;
            end
        end
    end
endmodule

// File: tb/tb_commit_trace_fifo.sv
// tb_commit_trace_fifo: directed self-checking bench for commit_trace_fifo
module tb_commit_trace_fifo;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        commit_valid = 1'b0;
    logic [31:0] commit_pc_rdata = '0;
    logic [31:0] commit_pc_wdata = '0;
    logic [31:0] commit_inst = '0;
    logic [4:0]  commit_rd_addr = '0;
    logic [31:0] commit_rd_wdata = '0;
    logic        commit_load_regfile = 1'b0;
    logic        commit_trap = 1'b0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_order;
    logic [31:0] out_pc, out_next_pc, out_inst, out_rd_wdata, drop_count;
    logic [4:0]  out_rd_addr;
    logic        out_trap, overflow, halted;
    logic [4:0]  count;
    int checks = 0;
    int failures = 0;

    commit_trace_fifo #(.DEPTH(16), .ORDER_W(64)) dut (
        .clk(clk), .rst(rst), .commit_valid(commit_valid),
        .commit_pc_rdata(commit_pc_rdata), .commit_pc_wdata(commit_pc_wdata),
        .commit_inst(commit_inst), .commit_rd_addr(commit_rd_addr),
        .commit_rd_wdata(commit_rd_wdata), .commit_load_regfile(commit_load_regfile),
        .commit_trap(commit_trap), .flush(flush), .out_valid(out_valid),
        .out_ready(out_ready), .out_order(out_order), .out_pc(out_pc),
        .out_next_pc(out_next_pc), .out_inst(out_inst), .out_rd_addr(out_rd_addr),
        .out_rd_wdata(out_rd_wdata), .out_trap(out_trap), .count(count),
        .overflow(overflow), .drop_count(drop_count), .halted(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_commit(input logic [31:0] pc, input logic [31:0] npc, input logic [4:0] rd,
                              input logic [31:0] wd, input logic ld, input logic trap);
        commit_valid        = 1'b1;
        commit_pc_rdata     = pc;
        commit_pc_wdata     = npc;
        commit_inst         = 32'h0000_0013 ^ pc;
        commit_rd_addr      = rd;
        commit_rd_wdata     = wd;
        commit_load_regfile = ld;
        commit_trap         = trap;
    endtask

    initial begin
        #3;
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        chk("rst_drops", 64'(drop_count), 64'd0);
        chk("rst_halted", 64'(halted), 64'd0);
        chk("rst_order", out_order, 64'd0);
        chk("rst_pc", 64'(out_pc), 64'd0);
        #9 rst = 1'b1;
        tick();

        // directed drain of three commits
        out_ready = 1'b1;
        set_commit(32'h6000_0000, 32'h6000_0004, 5'd1, 32'h11, 1'b1, 1'b0);
        chk("t1_valid_before", 64'(out_valid), 64'd0);
        tick();
        chk("t1_valid_rise", 64'(out_valid), 64'd1);
        chk("t1_order0", out_order, 64'd0);
        chk("t1_pc0", 64'(out_pc), 64'h6000_0000);
        chk("t1_npc0", 64'(out_next_pc), 64'h6000_0004);
        chk("t1_inst0", 64'(out_inst), 64'h6000_0013);
        chk("t1_wd0", 64'(out_rd_wdata), 64'h11);
        set_commit(32'h6000_0004, 32'h6000_0008, 5'd2, 32'h22, 1'b1, 1'b0);
        tick();
        chk("t1_order1", out_order, 64'd1);
        chk("t1_pc1", 64'(out_pc), 64'h6000_0004);
        set_commit(32'h6000_0008, 32'h6000_000C, 5'd3, 32'h33, 1'b1, 1'b0);
        tick();
        commit_valid = 1'b0;
        chk("t1_order2", out_order, 64'd2);
        chk("t1_pc2", 64'(out_pc), 64'h6000_0008);
        chk("t1_count1", 64'(count), 64'd1);
        tick();
        chk("t1_count0", 64'(count), 64'd0);
        chk("t1_valid_fall", 64'(out_valid), 64'd0);

        // restart order numbering for the overflow scenario
        rst = 1'b0;
        #2 rst = 1'b1;
        out_ready = 1'b0;
        for (int i = 0; i < 18; i++) begin
            set_commit(32'h6000_0000 + 32'(4 * i), 32'h6000_0004 + 32'(4 * i), 5'd1, 32'(i), 1'b1, 1'b0);
            tick();
        end
        commit_valid = 1'b0;
        chk("t2_count", 64'(count), 64'd16);
        chk("t2_overflow", 64'(overflow), 64'd1);
        chk("t2_drops", 64'(drop_count), 64'd2);
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t2_drain_order", out_order, 64'(i));
            tick();
        end
        chk("t2_empty", 64'(count), 64'd0);
        set_commit(32'h6000_0100, 32'h6000_0104, 5'd1, 32'h1, 1'b1, 1'b0);
        tick();
        commit_valid = 1'b0;
        chk("t2_next_order", out_order, 64'd18);
        tick();

        // full with simultaneous push and pop
        out_ready = 1'b0;
        for (int i = 0; i < 16; i++) begin
            set_commit(32'h6000_0200 + 32'(4 * i), 32'h6000_0204 + 32'(4 * i), 5'd1, 32'(i), 1'b1, 1'b0);
            tick();
        end
        chk("t3_full", 64'(count), 64'd16);
        chk("t3_head", out_order, 64'd19);
        set_commit(32'h7000_0000, 32'h7000_0004, 5'd9, 32'h99, 1'b1, 1'b0);
        out_ready = 1'b1;
        tick();
        commit_valid = 1'b0;
        chk("t3_count_same", 64'(count), 64'd16);
        chk("t3_drops_same", 64'(drop_count), 64'd2);
        chk("t3_head_adv", out_order, 64'd20);
        for (int i = 0; i < 15; i++) tick();
        chk("t3_tail_order", out_order, 64'd35);
        chk("t3_tail_pc", 64'(out_pc), 64'h7000_0000);
        tick();
        chk("t3_empty", 64'(count), 64'd0);

        // halt on self-loop
        out_ready = 1'b0;
        set_commit(32'h6000_00A0, 32'h6000_00A0, 5'd0, 32'h0, 1'b0, 1'b0);
        tick();
        chk("t4_halted", 64'(halted), 64'd1);
        chk("t4_count", 64'(count), 64'd1);
        chk("t4_order", out_order, 64'd36);
        for (int i = 0; i < 5; i++) begin
            set_commit(32'h6000_0300 + 32'(4 * i), 32'h6000_0304 + 32'(4 * i), 5'd1, 32'h5, 1'b1, 1'b0);
            tick();
        end
        commit_valid = 1'b0;
        chk("t4_count_held", 64'(count), 64'd1);
        chk("t4_drops_held", 64'(drop_count), 64'd2);
        chk("t4_still_halted", 64'(halted), 64'd1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_halt", 64'(halted), 64'd0);
        chk("t4_flush_count", 64'(count), 64'd0);
        chk("t4_flush_ovf", 64'(overflow), 64'd0);
        chk("t4_flush_drops", 64'(drop_count), 64'd0);
        set_commit(32'h6000_0400, 32'h6000_0404, 5'd1, 32'h1, 1'b1, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("t4_flush_discard", 64'(count), 64'd0);
        set_commit(32'h0, 32'h0, 5'd1, 32'h1, 1'b1, 1'b0);
        tick();
        commit_valid = 1'b0;
        chk("t4_pc0_nohalt", 64'(halted), 64'd0);
        chk("t4_pc0_count", 64'(count), 64'd1);
        chk("t4_pc0_order", out_order, 64'd37);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;

        // rd data masking and trap flag
        set_commit(32'h6000_0500, 32'h6000_0504, 5'd0, 32'hDEAD_BEEF, 1'b1, 1'b0);
        tick();
        set_commit(32'h6000_0504, 32'h6000_0508, 5'd5, 32'h1234_5678, 1'b0, 1'b0);
        tick();
        set_commit(32'h6000_0508, 32'h6000_050C, 5'd7, 32'hCAFE_F00D, 1'b1, 1'b1);
        tick();
        commit_valid = 1'b0;
        chk("t5_rd0_addr", 64'(out_rd_addr), 64'd0);
        chk("t5_rd0_mask", 64'(out_rd_wdata), 64'd0);
        chk("t5_order", out_order, 64'd38);
        out_ready = 1'b1;
        tick();
        chk("t5_nold_addr", 64'(out_rd_addr), 64'd5);
        chk("t5_nold_mask", 64'(out_rd_wdata), 64'd0);
        chk("t5_nold_trap", 64'(out_trap), 64'd0);
        tick();
        chk("t5_keep_data", 64'(out_rd_wdata), 64'hCAFE_F00D);
        chk("t5_trap", 64'(out_trap), 64'd1);
        chk("t5_trap_nohalt", 64'(halted), 64'd0);
        tick();
        chk("t5_empty", 64'(count), 64'd0);

        // asynchronous reset mid-operation
        out_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            set_commit(32'h6000_0600 + 32'(4 * i), 32'h6000_0604 + 32'(4 * i), 5'd2, 32'(i), 1'b1, 1'b0);
            tick();
        end
        commit_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 9; i++) tick();
        out_ready = 1'b0;
        chk("t6_pre_count", 64'(count), 64'd7);
        chk("t6_pre_ovf", 64'(overflow), 64'd1);
        rst = 1'b0;
        #1;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_count", 64'(count), 64'd0);
        chk("t6_ovf", 64'(overflow), 64'd0);
        chk("t6_drops", 64'(drop_count), 64'd0);
        chk("t6_halted", 64'(halted), 64'd0);
        chk("t6_order_out", out_order, 64'd0);
        chk("t6_pc_out", 64'(out_pc), 64'd0);
        #2 rst = 1'b1;
        set_commit(32'h6000_0700, 32'h6000_0704, 5'd1, 32'h1, 1'b1, 1'b0);
        tick();
        commit_valid = 1'b0;
        chk("t6_order_restart", out_order, 64'd0);
        chk("t6_count_after", 64'(count), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
